// File: rtl/sram_b_burst_reader.sv
// ---------------------------------------------------------------------------
// sram_b_burst_reader
//
// Read-side burst initiator for the sram_b family of banked SRAM wrappers.
// It accepts one burst request (start address + length-1) and drives the
// SRAM read port (CE1/A1). The returned words go out on a valid/ready stream
// with a last-word flag. A 2-entry output FIFO with credit accounting covers
// the one-cycle SRAM read latency. This lets the block sustain one word per
// cycle without ever overflowing the FIFO.
//
// Optional feature macro: SRAM_B_READER_ERR_EN
//   When defined, adds the sticky 'err' output. It is set at request
//   acceptance if the burst wraps past the top of the address space.
//
// Parameters:
//   ABITS     SRAM address width (also the width of req_len)
//   DBITS     SRAM data width
//
// Ports:
//   CLK        clock, rising edge
//   RSTN       synchronous active-low reset
//   req_valid  burst request valid
//   req_ready  request accepted when high with req_valid (high only in IDLE)
//   req_addr   first word address
//   req_len    burst length minus one
//   CE1        SRAM read enable (combinational from out_ready via credit)
//   A1         SRAM read address
//   Q1         SRAM read data, valid the cycle after CE1
//   out_valid  output word valid
//   out_ready  consumer ready
//   out_data   output word (FIFO head)
//   out_last   final word of the burst, qualified by out_valid
//   err        (SRAM_B_READER_ERR_EN only) sticky address-wrap flag
// ---------------------------------------------------------------------------
module sram_b_burst_reader #(
  parameter int ABITS = 12,
  parameter int DBITS = 8
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ABITS-1:0] req_addr,
  input  logic [ABITS-1:0] req_len,
  output logic             CE1,
  output logic [ABITS-1:0] A1,
  input  logic [DBITS-1:0] Q1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DBITS-1:0] out_data,
  output logic             out_last
`ifdef SRAM_B_READER_ERR_EN
  ,
  output logic             err
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [ABITS-1:0] addr_q;
  logic [ABITS-1:0] remain_q;
  logic             inflight_q;
  logic             inflight_last_q;

  logic [DBITS-1:0] fifo_data [2];
  logic             fifo_last [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       fifo_count;

  logic             pop;
  logic             push;
  logic [2:0]       occupancy;
  logic             credit_ok;
  logic             issue_last;

  // A slot is committed once a read is in flight or its word sits in the FIFO.
  // A pop in this same cycle frees a slot, so out_ready feeds CE1
  // combinationally. That path keeps the block at full rate.
  assign pop        = out_valid & out_ready;
  assign push       = inflight_q;
  assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign credit_ok  = (occupancy - {2'b00, pop}) < 3'd2;

  assign req_ready  = (state == IDLE);
  assign CE1        = (state == ISSUE) & credit_ok;
  assign A1         = addr_q;
  assign issue_last = CE1 & (remain_q == '0);

  assign out_valid  = (fifo_count != 2'd0);
  assign out_data   = fifo_data[rd_ptr];
  assign out_last   = fifo_last[rd_ptr];

`ifdef SRAM_B_READER_ERR_EN
  logic [ABITS:0] end_sum;
  // A carry out of addr+len means the burst runs past the top address.
  assign end_sum = {1'b0, req_addr} + {1'b0, req_len};
`endif

  // Burst control FSM. It also owns the address/remaining counters and the
  // one-deep in-flight tracker that carries the last tag alongside the read.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state           <= IDLE;
      addr_q          <= '0;
      remain_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
`ifdef SRAM_B_READER_ERR_EN
      err             <= 1'b0;
`endif
    end else begin
      inflight_q      <= CE1;
      inflight_last_q <= issue_last;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            remain_q <= req_len;
            state    <= ISSUE;
`ifdef SRAM_B_READER_ERR_EN
            if (end_sum[ABITS]) begin
              err <= 1'b1;
            end
`endif
          end
        end
        ISSUE: begin
          if (CE1) begin
            addr_q   <= addr_q + 1'b1;
            remain_q <= remain_q - 1'b1;
            if (remain_q == '0) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && out_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-entry output FIFO. A read issued last cycle lands here now. Credit
  // accounting guarantees a free slot whenever push is high.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= Q1;
        fifo_last[wr_ptr] <= inflight_last_q;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_b_burst_reader.sv
// ---------------------------------------------------------------------------
// tb_sram_b_burst_reader
//
// Self-checking bench for sram_b_burst_reader. A behavioural SRAM (one-cycle
// read latency) backs the read port. Expected words come from the memory
// image using the burst rule word[i] = mem[(addr + i) mod 4096], with last
// set only on i == len. Define SRAM_B_READER_ERR_EN to also check err.
// ---------------------------------------------------------------------------
module tb_sram_b_burst_reader;

  localparam int ABITS = 12;
  localparam int DBITS = 8;

  logic             CLK;
  logic             RSTN;
  logic             req_valid;
  logic             req_ready;
  logic [ABITS-1:0] req_addr;
  logic [ABITS-1:0] req_len;
  logic             CE1;
  logic [ABITS-1:0] A1;
  logic [DBITS-1:0] Q1;
  logic             out_valid;
  logic             out_ready;
  logic [DBITS-1:0] out_data;
  logic             out_last;
`ifdef SRAM_B_READER_ERR_EN
  logic             err;
`endif

  sram_b_burst_reader #(.ABITS(ABITS), .DBITS(DBITS)) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .CE1       (CE1),
    .A1        (A1),
    .Q1        (Q1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
`ifdef SRAM_B_READER_ERR_EN
    ,
    .err       (err)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Behavioural SRAM read port: data appears the cycle after CE1.
  logic [DBITS-1:0] mem [4096];
  always @(posedge CLK) begin
    if (CE1) begin
      Q1 <= mem[A1];
    end
  end

  int checks;
  int failures;

  // Observations recorded by run_burst, cycle numbers relative to accept edge T.
  logic [ABITS-1:0] a1_q [$];
  int               ce_cyc [$];
  logic [DBITS-1:0] od_q [$];
  logic             ol_q [$];
  int               oc_q [$];
  int               max_outstanding;
  int               stab_err;
  int               done_cyc;
  int               timed_out;
  logic             rr_at1;
  logic             err_at1;

  // Drives one request and records CE1/A1 and every pop until the last pop
  // or until stop_pops words have been popped. Mode 0 keeps out_ready high;
  // mode 1 toggles it randomly, with a forced 20-cycle stall window.
  task automatic run_burst(input logic [ABITS-1:0] addr, input logic [ABITS-1:0] len,
                           input int mode, input int stop_pops);
    int   issued;
    int   popped;
    int   budget;
    int   waited;
    logic prev_stall;
    logic [DBITS-1:0] prev_data;
    logic prev_last;
    a1_q.delete(); ce_cyc.delete(); od_q.delete(); ol_q.delete(); oc_q.delete();
    max_outstanding = 0; stab_err = 0; done_cyc = -1; timed_out = 0;
    rr_at1 = 1'bx; err_at1 = 1'b0;
    issued = 0; popped = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    budget = 200 + 4 * int'(len);
    waited = 0;
    @(negedge CLK);
    while (!req_ready && waited < 50) begin
      @(negedge CLK);
      waited++;
    end
    if (!req_ready) begin
      timed_out = 1;
      return;
    end
    req_valid = 1'b1;
    req_addr  = addr;
    req_len   = len;
    @(posedge CLK);
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge CLK);
      req_valid = 1'b0;
      if (mode == 0) out_ready = 1'b1;
      else if (cyc >= 4 && cyc < 24) out_ready = 1'b0;
      else out_ready = 1'($urandom_range(0, 1));
      #1;
      if (cyc == 1) begin
        rr_at1 = req_ready;
`ifdef SRAM_B_READER_ERR_EN
        err_at1 = err;
`endif
      end
      if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
        stab_err++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (CE1) begin
        a1_q.push_back(A1);
        ce_cyc.push_back(cyc);
        issued++;
      end
      if (out_valid && out_ready) begin
        od_q.push_back(out_data);
        ol_q.push_back(out_last);
        oc_q.push_back(cyc);
        popped++;
      end
      if (issued - popped > max_outstanding) max_outstanding = issued - popped;
      if (out_valid && out_ready && out_last) begin
        done_cyc = cyc;
        return;
      end
      if (stop_pops > 0 && popped >= stop_pops) begin
        done_cyc = cyc;
        return;
      end
    end
    timed_out = 1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RSTN = 1'b0;
    req_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (req_ready !== 1'b1 || CE1 !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_idle: req_ready=%b CE1=%b out_valid=%b, required 1/0/0",
               req_ready, CE1, out_valid);
    end
    checks++;
    if (A1 !== '0 || out_data !== '0 || out_last !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_values: A1=%h out_data=%h out_last=%b, required 0/0/0",
               A1, out_data, out_last);
    end
`ifdef SRAM_B_READER_ERR_EN
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_err: err=%b, required 0", err);
    end
`endif
  endtask

  task automatic test_single();
    mem[12'h123] = 8'hA5;
    run_burst(12'h123, 12'd0, 0, 0);
    checks++;
    if (timed_out != 0 || ce_cyc.size() != 1 || ce_cyc[0] != 1 || a1_q[0] !== 12'h123) begin
      failures++;
      $display("[TB] FAIL single_issue: timeout=%0d ce_count=%0d, required one CE1 at T+1 with A1=123",
               timed_out, ce_cyc.size());
    end
    checks++;
    if (od_q.size() != 1 || oc_q[0] != 3 || od_q[0] !== 8'hA5 || ol_q[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_output: pops=%0d, required one pop of A5 with last at T+3",
               od_q.size());
    end
    @(negedge CLK);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_ready_after: req_ready=%b, required 1", req_ready);
    end
  endtask

  task automatic test_full_rate();
    int bad_a1;
    int bad_out;
    bad_a1 = 0; bad_out = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    run_burst(12'h000, 12'd15, 0, 0);
    checks++;
    if (rr_at1 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL full_busy: req_ready=%b during burst, required 0", rr_at1);
    end
    for (int i = 0; i < a1_q.size(); i++)
      if (a1_q[i] !== 12'(i) || ce_cyc[i] != i + 1) bad_a1++;
    checks++;
    if (a1_q.size() != 16 || bad_a1 != 0) begin
      failures++;
      $display("[TB] FAIL full_issue: ce_count=%0d bad=%0d, required 16 consecutive A1 0..15",
               a1_q.size(), bad_a1);
    end
    for (int i = 0; i < od_q.size(); i++)
      if (od_q[i] !== 8'(i) || oc_q[i] != i + 3 || ol_q[i] !== (i == 15)) bad_out++;
    checks++;
    if (od_q.size() != 16 || bad_out != 0) begin
      failures++;
      $display("[TB] FAIL full_output: pops=%0d bad=%0d, required 00..0F consecutive, last on 0F",
               od_q.size(), bad_out);
    end
    checks++;
    if (done_cyc != 18) begin
      failures++;
      $display("[TB] FAIL full_done: last pop at T+%0d, required T+18", done_cyc);
    end
  endtask

  task automatic test_backpressure(input logic [ABITS-1:0] addr, input logic [ABITS-1:0] len,
                                   input string tag);
    int bad;
    bad = 0;
    run_burst(addr, len, 1, 0);
    for (int i = 0; i < od_q.size(); i++)
      if (od_q[i] !== mem[12'(int'(addr) + i)] || ol_q[i] !== (i == int'(len))) bad++;
    checks++;
    if (timed_out != 0 || od_q.size() != int'(len) + 1 || bad != 0) begin
      failures++;
      $display("[TB] FAIL %s_data: timeout=%0d pops=%0d bad=%0d, required %0d in-order words",
               tag, timed_out, od_q.size(), bad, int'(len) + 1);
    end
    checks++;
    if (max_outstanding > 2 || a1_q.size() != int'(len) + 1) begin
      failures++;
      $display("[TB] FAIL %s_credit: max_outstanding=%0d reads=%0d, required <=2 and %0d",
               tag, max_outstanding, a1_q.size(), int'(len) + 1);
    end
    checks++;
    if (stab_err != 0) begin
      failures++;
      $display("[TB] FAIL %s_stable: %0d stall violations, required 0", tag, stab_err);
    end
  endtask

  task automatic test_wrap();
    logic [ABITS-1:0] exp_a1 [4];
    int bad;
    exp_a1[0] = 12'hFFE; exp_a1[1] = 12'hFFF; exp_a1[2] = 12'h000; exp_a1[3] = 12'h001;
    bad = 0;
    run_burst(12'hFFE, 12'd3, 0, 0);
    for (int i = 0; i < a1_q.size() && i < 4; i++) begin
      if (a1_q[i] !== exp_a1[i]) bad++;
      if (i < od_q.size() && od_q[i] !== mem[exp_a1[i]]) bad++;
    end
    checks++;
    if (a1_q.size() != 4 || od_q.size() != 4 || bad != 0) begin
      failures++;
      $display("[TB] FAIL wrap_seq: reads=%0d pops=%0d bad=%0d, required FFE,FFF,000,001",
               a1_q.size(), od_q.size(), bad);
    end
`ifdef SRAM_B_READER_ERR_EN
    checks++;
    if (err_at1 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL wrap_err: err=%b at T+1, required 1", err_at1);
    end
`endif
    do_reset();
    run_burst(12'h100, 12'd3, 0, 0);
    checks++;
    if (od_q.size() != 4 || od_q[3] !== mem[12'h103] || a1_q[3] !== 12'h103) begin
      failures++;
      $display("[TB] FAIL nowrap_seq: pops=%0d, required 4 words ending at 103", od_q.size());
    end
`ifdef SRAM_B_READER_ERR_EN
    checks++;
    if (err_at1 !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL nowrap_err: err=%b, required 0", err);
    end
`endif
  endtask

  task automatic test_reset_mid_burst();
    run_burst(12'h010, 12'd7, 0, 3);
    checks++;
    if (od_q.size() != 3 || od_q[2] !== mem[12'h012]) begin
      failures++;
      $display("[TB] FAIL midrst_pops: pops=%0d, required 3 words from 010", od_q.size());
    end
    RSTN = 1'b0;
    @(negedge CLK);
    #1;
    checks++;
    if (CE1 !== 1'b0 || out_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midrst_abort: CE1=%b out_valid=%b req_ready=%b, required 0/0/1",
               CE1, out_valid, req_ready);
    end
    RSTN = 1'b1;
  endtask

  task automatic test_back_to_back();
    int bad;
    bad = 0;
    run_burst(12'h200, 12'd2, 0, 0);
    for (int i = 0; i < od_q.size(); i++) if (od_q[i] !== mem[12'h200 + 12'(i)]) bad++;
    run_burst(12'h300, 12'd4, 0, 0);
    for (int i = 0; i < od_q.size(); i++) if (od_q[i] !== mem[12'h300 + 12'(i)]) bad++;
    checks++;
    if (timed_out != 0 || od_q.size() != 5 || bad != 0 || done_cyc != 7) begin
      failures++;
      $display("[TB] FAIL back_to_back: timeout=%0d pops=%0d bad=%0d done=T+%0d, required 5/0/T+7",
               timed_out, od_q.size(), bad, done_cyc);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    RSTN = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    req_len = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    test_reset();
    test_single();
    test_full_rate();
    test_backpressure(12'h040, 12'd9, "bp");
    test_reset_mid_burst();
    test_back_to_back();
    test_wrap();
    for (int k = 0; k < 3; k++)
      test_backpressure(12'($urandom_range(0, 4000)), 12'($urandom_range(0, 20)), "rand");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
